// File: rtl/serial_receiver.sv
// serial_receiver: asynchronous serial frame receiver (start, N data bits LSB first, stop) with mid-bit sampling.
module serial_receiver #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clock,
  input  logic         resetp,
  input  logic         rxd,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         frame_err,
  output logic         busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic          tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  q_q, q_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clock or posedge resetp) begin
    if (resetp) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  // The start bit is sampled half a bit period after t0; every later sample is one full period on.
  assign tick = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

  // Next-state, counters, shift register and one-cycle result pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    q_d     = q_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (tick) begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = N'({rxd_s, shift_q} >> 1);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = STOP;
      end
      STOP: if (tick) begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : WAIT_HIGH;
        q_d     = rxd_s ? shift_q : q_q;
        valid_d = rxd_s;
        err_d   = !rxd_s;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress without a pulse.
  always_ff @(posedge clock or posedge resetp) begin
    if (resetp) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign q         = q_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);
endmodule
